// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared types and constants for the arm command arbiter
package arm_pkg;

  typedef enum logic [1:0] {
    MODE_SELECT = 2'b00,
    MODE_US     = 2'b01,
    MODE_KB     = 2'b10,
    MODE_AN     = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_HOME,
    ST_SETTLE,
    ST_TRACK
  } arb_state_t;

  typedef logic [7:0] pos_t;

  localparam pos_t HOME_POS = 8'd128;

  // Move toward tgt by at most step; never overshoots, so 8-bit math cannot wrap.
  function automatic pos_t slew_toward(input pos_t pos, input pos_t tgt, input pos_t step);
    pos_t diff;
    if (tgt > pos) begin
      diff = tgt - pos;
      return (diff <= step) ? tgt : pos + step;
    end else begin
      diff = pos - tgt;
      return (diff <= step) ? tgt : pos - step;
    end
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running divider producing a one-cycle tick every TICK_DIV clocks
module tick_gen #(
  parameter int TICK_DIV = 10000
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [W-1:0] r_cnt;

  assign o_tick = (r_cnt == W'(TICK_DIV - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/arm_cmd_arbiter.sv
// rtl/arm_cmd_arbiter.sv - mode-gated arbiter of three position sources driving one servo
// ARM_SLEW_LIMIT_EN: when defined, servo_pos slews toward target by STEP per tick_gen tick.
module arm_cmd_arbiter
  import arm_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1000
`ifdef ARM_SLEW_LIMIT_EN
  ,
  parameter int TICK_DIV = 10000,
  parameter int STEP     = 2
`endif
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_state,
  input  logic       i_us_valid,
  input  logic [7:0] i_us_pos,
  input  logic       i_kb_valid,
  input  logic [7:0] i_kb_pos,
  input  logic       i_an_valid,
  input  logic [7:0] i_an_pos,
  output logic       o_us_ready,
  output logic       o_kb_ready,
  output logic       o_an_ready,
  output logic [7:0] o_servo_pos,
  output logic       o_servo_update,
  output logic       o_busy
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  arb_state_t r_fsm, w_fsm_next;
  mode_t      r_mode_q;
  logic [SW-1:0] r_settle_cnt;
  pos_t       r_target, w_tgt_next;
  pos_t       r_servo_pos, w_pos_next;
  logic       r_servo_update;
  logic       w_mode_chg, w_settle_done, w_track, w_slew_en;
  logic       w_us_rdy, w_kb_rdy, w_an_rdy;

`ifdef ARM_SLEW_LIMIT_EN
  logic w_tick;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .o_tick (w_tick)
  );
`endif

  always_comb begin
    w_mode_chg    = (i_state != r_mode_q);
    w_settle_done = (r_fsm == ST_SETTLE) && (r_settle_cnt == SW'(SETTLE_CYCLES - 1));

    w_fsm_next = r_fsm;
    if (w_mode_chg) begin
      w_fsm_next = ST_SETTLE;
    end else if (w_settle_done) begin
      w_fsm_next = (r_mode_q == MODE_SELECT) ? ST_HOME : ST_TRACK;
    end

    // Readys drop in the mode-change cycle so nothing is accepted as SETTLE begins.
    w_track  = (r_fsm == ST_TRACK) && !w_mode_chg;
    w_us_rdy = w_track && (r_mode_q == MODE_US);
    w_kb_rdy = w_track && (r_mode_q == MODE_KB);
    w_an_rdy = w_track && (r_mode_q == MODE_AN);

    w_tgt_next = r_target;
    if (w_fsm_next == ST_HOME) begin
      w_tgt_next = HOME_POS;
    end else if (w_us_rdy && i_us_valid) begin
      w_tgt_next = i_us_pos;
    end else if (w_kb_rdy && i_kb_valid) begin
      w_tgt_next = i_kb_pos;
    end else if (w_an_rdy && i_an_valid) begin
      w_tgt_next = i_an_pos;
    end

    w_slew_en  = ((r_fsm == ST_HOME) || (r_fsm == ST_TRACK)) && !w_mode_chg;
    w_pos_next = r_servo_pos;
`ifdef ARM_SLEW_LIMIT_EN
    if (w_slew_en && w_tick) begin
      w_pos_next = slew_toward(r_servo_pos, r_target, pos_t'(STEP));
    end
`else
    if (w_slew_en) begin
      w_pos_next = r_target;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fsm          <= ST_HOME;
      r_mode_q       <= MODE_SELECT;
      r_settle_cnt   <= '0;
      r_target       <= HOME_POS;
      r_servo_pos    <= HOME_POS;
      r_servo_update <= 1'b0;
    end else begin
      r_fsm          <= w_fsm_next;
      r_target       <= w_tgt_next;
      r_servo_pos    <= w_pos_next;
      r_servo_update <= (w_pos_next != r_servo_pos);
      if (w_mode_chg) begin
        r_mode_q     <= mode_t'(i_state);
        r_settle_cnt <= '0;
      end else if (r_fsm == ST_SETTLE) begin
        r_settle_cnt <= r_settle_cnt + SW'(1);
      end
    end
  end

  assign o_us_ready     = w_us_rdy;
  assign o_kb_ready     = w_kb_rdy;
  assign o_an_ready     = w_an_rdy;
  assign o_servo_pos    = r_servo_pos;
  assign o_servo_update = r_servo_update;
  assign o_busy         = (r_fsm == ST_SETTLE) || (r_servo_pos != r_target);

endmodule
